// File: rtl/fetch_controller_if.sv
// Fetch-stage bus: instruction-memory read port, redirect/halt controls and
// the decode-side valid/ready output slot.
interface fetch_controller_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        output halt_req,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/fetch_controller.sv
// Single-slot instruction fetch controller: sequential fetch from a combinational
// instruction memory, with redirect, halt, range/alignment faults and a transfer counter.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter int          MEM_DEPTH = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fetch_controller_if.master        bus,
    output logic [1:0]                state,
    output logic [15:0]               fetch_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic [30:0] DEPTH_WORDS = 31'(MEM_DEPTH);

    state_t      cur_state, next_state;
    logic [31:0] pc, pc_next;
    logic        valid_q, valid_next, load_slot;
    logic [31:0] instr_q, slot_pc_q;
    logic        slot_free, transfer, in_range;

    assign transfer  = valid_q && bus.out_ready;
    assign slot_free = !valid_q || bus.out_ready;
    assign in_range  = {1'b0, pc[31:2]} < DEPTH_WORDS;

    assign bus.imem_addr = pc;
    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_pc    = slot_pc_q;
    assign state         = cur_state;

    // Redirect outranks halt and fetch everywhere except the sticky fault state;
    // a flushed slot may still be accepted by decode in the same cycle.
    always_comb begin
        next_state = cur_state;
        pc_next    = pc;
        valid_next = valid_q;
        load_slot  = 1'b0;
        if (cur_state != FAULT && bus.redirect_valid) begin
            valid_next = 1'b0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                next_state = FAULT;
            end else begin
                pc_next    = bus.redirect_pc;
                next_state = FETCH;
            end
        end else begin
            case (cur_state)
                IDLE: begin
                    valid_next = 1'b0;
                    next_state = FETCH;
                end
                FETCH: begin
                    if (slot_free) begin
                        if (bus.halt_req) begin
                            valid_next = 1'b0;
                            next_state = HALTED;
                        end else if (!in_range) begin
                            valid_next = 1'b0;
                            next_state = FAULT;
                        end else begin
                            load_slot  = 1'b1;
                            valid_next = 1'b1;
                            pc_next    = pc + 32'd4;
                        end
                    end
                end
                default: valid_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
            pc        <= RESET_PC;
            valid_q   <= 1'b0;
            instr_q   <= 32'd0;
            slot_pc_q <= 32'd0;
        end else begin
            cur_state <= next_state;
            pc        <= pc_next;
            valid_q   <= valid_next;
            if (load_slot) begin
                instr_q   <= bus.imem_data;
                slot_pc_q <= pc;
            end
        end
    end

    // Saturating count of accepted transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 16'd0;
        end else if (transfer && fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end

endmodule
